// File: rtl/matrix_pkg.sv
// Shared constants, scan FSM states and the row-select helper for the 8x8 matrix scanner.
package matrix_pkg;

    localparam int ROWS   = 8;
    localparam int COLS   = 8;
    localparam int WORD_W = 16;
    localparam int ROW_W  = $clog2(ROWS);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DWELL
    } scan_state_t;

    // Active-low one-hot-zero row select: only the selected row's bit is 0.
    function automatic logic [ROWS-1:0] row_select(input logic [ROW_W-1:0] row);
        return ~(ROWS'(1) << row);
    endfunction

endpackage

// File: rtl/matrix_fb.sv
// Double frame buffer: writes land in the back bank, reads come from the front bank,
// and a swap only flips the front-select bit (nothing is copied).
module matrix_fb
    import matrix_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [ROW_W-1:0] wr_row,
    input  logic [COLS-1:0]  wr_data,
    input  logic [ROW_W-1:0] rd_row,
    output logic [COLS-1:0]  rd_data,
    input  logic             swap,
    output logic             front_sel
);

    logic [COLS-1:0] bank0 [ROWS];
    logic [COLS-1:0] bank1 [ROWS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            front_sel <= 1'b0;
            for (int i = 0; i < ROWS; i++) begin
                bank0[i] <= '0;
                bank1[i] <= '0;
            end
        end else begin
            // A write and a swap on the same edge both use the pre-swap back bank.
            if (wr_en) begin
                if (front_sel) begin
                    bank0[wr_row] <= wr_data;
                end else begin
                    bank1[wr_row] <= wr_data;
                end
            end
            if (swap) begin
                front_sel <= ~front_sel;
            end
        end
    end

    assign rd_data = front_sel ? bank1[rd_row] : bank0[rd_row];

endmodule

// File: rtl/matrix_scan_ctrl.sv
// Row-multiplexed LED matrix scanner: loads one row word into an external shift driver,
// holds the row for a scaled dwell time, and swaps double buffers at frame boundaries.
module matrix_scan_ctrl
    import matrix_pkg::*;
#(
    parameter int DWELL_BASE = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  refresh_speed,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [2:0]  wr_row,
    input  logic [7:0]  wr_data,
    input  logic        swap_req,
    output logic        swap_ack,
    input  logic        shift_ready,
    output logic        shift_start,
    output logic [15:0] shift_word,
    input  logic        shift_done,
    output logic [2:0]  row_idx,
    output logic        frame_tick
);

    localparam int CNT_W = $clog2(DWELL_BASE + 1) + 3;

    scan_state_t      state_q;
    scan_state_t      state_d;
    logic [CNT_W-1:0] dwell_cnt;
    logic             pending;
    logic             start_row;
    logic             enter_dwell;
    logic             row_end;
    logic             frame_end;
    logic             swap_now;
    logic [7:0]       front_data;
    logic             front_sel;

    matrix_fb u_fb (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_valid && wr_ready),
        .wr_row    (wr_row),
        .wr_data   (wr_data),
        .rd_row    (row_idx),
        .rd_data   (front_data),
        .swap      (swap_now),
        .front_sel (front_sel)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        start_row   = 1'b0;
        enter_dwell = 1'b0;
        row_end     = 1'b0;
        case (state_q)
            IDLE: state_d = LOAD;
            LOAD: begin
                if (shift_ready) begin
                    start_row = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (shift_done) begin
                    enter_dwell = 1'b1;
                    state_d     = DWELL;
                end
            end
            DWELL: begin
                if (dwell_cnt == '0) begin
                    row_end = 1'b1;
                    state_d = LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign frame_end = row_end && (row_idx == 3'(ROWS - 1));
    assign swap_now  = frame_end && pending;

    // Dwell counts N..0, so a row stays lit for N+1 cycles after its shift completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_start <= 1'b0;
            shift_word  <= WORD_W'(16'h00FF);
            dwell_cnt   <= '0;
            row_idx     <= '0;
            frame_tick  <= 1'b0;
            swap_ack    <= 1'b0;
            wr_ready    <= 1'b0;
            pending     <= 1'b0;
        end else begin
            shift_start <= start_row;
            if (start_row) begin
                shift_word <= {front_data, row_select(row_idx)};
            end
            if (enter_dwell) begin
                dwell_cnt <= CNT_W'(DWELL_BASE) << refresh_speed;
            end else if (state_q == DWELL && dwell_cnt != '0) begin
                dwell_cnt <= dwell_cnt - CNT_W'(1);
            end
            if (row_end) begin
                row_idx <= row_idx + 3'd1;
            end
            frame_tick <= frame_end;
            swap_ack   <= swap_now;
            wr_ready   <= !swap_now;
            // A request arriving on the swap edge is kept for the following frame.
            pending    <= swap_now ? swap_req : (pending | swap_req);
        end
    end

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Directed bench for matrix_scan_ctrl: emulates the shift driver (done 4 cycles after start)
// and walks through scanning, double buffering, dwell scaling, stalls and mid-row reset.
module tb_matrix_scan_ctrl;

    localparam int DWELL_BASE  = 16;
    localparam int BASE_PERIOD = 23;
    localparam int SLOW_PERIOD = 135;
    localparam logic [7:0] SEL [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  refresh_speed;
    logic        wr_valid;
    logic        wr_ready;
    logic [2:0]  wr_row;
    logic [7:0]  wr_data;
    logic        swap_req;
    logic        swap_ack;
    logic        shift_ready;
    logic        shift_start;
    logic [15:0] shift_word;
    logic        shift_done;
    logic [2:0]  row_idx;
    logic        frame_tick;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int ft_cnt   = 0;
    int sa_cnt   = 0;
    int ss_cnt   = 0;
    int sa_alone = 0;

    matrix_scan_ctrl #(.DWELL_BASE(DWELL_BASE)) dut (
        .clk           (clk),
        .reset         (reset),
        .refresh_speed (refresh_speed),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_row        (wr_row),
        .wr_data       (wr_data),
        .swap_req      (swap_req),
        .swap_ack      (swap_ack),
        .shift_ready   (shift_ready),
        .shift_start   (shift_start),
        .shift_word    (shift_word),
        .shift_done    (shift_done),
        .row_idx       (row_idx),
        .frame_tick    (frame_tick)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_tick === 1'b1) ft_cnt++;
        if (swap_ack === 1'b1) sa_cnt++;
        if (shift_start === 1'b1) ss_cnt++;
        if (swap_ack === 1'b1 && frame_tick !== 1'b1) sa_alone++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic waitStart(input string tag, output int start_cyc);
        int n = 0;
        start_cyc = -1;
        while (n < 400 && start_cyc < 0) begin
            @(negedge clk);
            if (shift_start === 1'b1) start_cyc = cyc;
            n++;
        end
        if (start_cyc < 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s timeout waiting for shift_start observed=0 expected=1", tag);
        end
    endtask

    task automatic serveRow(input string tag, input logic [15:0] exp_word, output int start_cyc);
        waitStart(tag, start_cyc);
        if (start_cyc >= 0) begin
            checkOutput({tag, "_word"}, 32'(shift_word), 32'(exp_word));
            @(negedge clk);
            checkOutput({tag, "_one_pulse"}, 32'(shift_start), 0);
            repeat (3) @(posedge clk);
            #1 shift_done = 1'b1;
            checkOutput({tag, "_hold"}, 32'(shift_word), 32'(exp_word));
            @(posedge clk);
            #1 shift_done = 1'b0;
        end
    endtask

    task automatic serveRows(input string tag, input int first, input int last,
                             input logic [7:0] d2, input logic [7:0] d3, inout int t_prev);
        int t_now;
        logic [7:0] d;
        for (int r = first; r <= last; r++) begin
            d = (r == 2) ? d2 : ((r == 3) ? d3 : 8'h00);
            serveRow($sformatf("%s_row%0d", tag, r), {d, SEL[r]}, t_now);
            if (t_prev >= 0) checkOutput($sformatf("%s_period%0d", tag, r), t_now - t_prev, BASE_PERIOD);
            t_prev = t_now;
        end
    endtask

    task automatic waitTick(input string tag, input logic exp_ack);
        int n = 0;
        bit seen = 1'b0;
        while (n < 400 && !seen) begin
            @(negedge clk);
            if (frame_tick === 1'b1) seen = 1'b1;
            n++;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s timeout waiting for frame_tick observed=0 expected=1", tag);
        end
        checkOutput({tag, "_row0"}, 32'(row_idx), 0);
        checkOutput({tag, "_swap_ack"}, 32'(swap_ack), 32'(exp_ack));
        checkOutput({tag, "_wr_ready"}, 32'(wr_ready), 32'(!exp_ack));
    endtask

    task automatic applyStimulus(input logic [2:0] row, input logic [7:0] data);
        bit accepted = 1'b0;
        int n = 0;
        @(posedge clk);
        #1;
        wr_valid = 1'b1;
        wr_row   = row;
        wr_data  = data;
        while (!accepted && n < 10) begin
            @(negedge clk);
            accepted = (wr_ready === 1'b1);
            @(posedge clk);
            #1;
            n++;
        end
        wr_valid = 1'b0;
        checkOutput("write_accepted", 32'(accepted), 1);
    endtask

    task automatic pulseSwap();
        @(posedge clk);
        #1 swap_req = 1'b1;
        @(posedge clk);
        #1 swap_req = 1'b0;
    endtask

    initial begin
        int t_prev;
        int t_now;
        int snap;

        reset         = 1'b1;
        refresh_speed = 2'd0;
        wr_valid      = 1'b0;
        wr_row        = 3'd0;
        wr_data       = 8'h00;
        swap_req      = 1'b0;
        shift_ready   = 1'b1;
        shift_done    = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_word", 32'(shift_word), 32'h00FF);
        checkOutput("rst_start", 32'(shift_start), 0);
        checkOutput("rst_row", 32'(row_idx), 0);
        checkOutput("rst_tick", 32'(frame_tick), 0);
        checkOutput("rst_ack", 32'(swap_ack), 0);
        checkOutput("rst_wr_ready", 32'(wr_ready), 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Frame A: row 3 written to back buffer, two swap requests merge into one swap.
        serveRow("a_row0", 16'h00FE, t_prev);
        applyStimulus(3'd3, 8'hA5);
        pulseSwap();
        pulseSwap();
        serveRows("a", 1, 7, 8'h00, 8'h00, t_prev);

        // A->B boundary: write and re-request during the swap cycle.
        waitTick("ab", 1'b1);
        wr_valid = 1'b1;
        wr_row   = 3'd2;
        wr_data  = 8'h3C;
        swap_req = 1'b1;
        fork
            serveRow("b_row0", 16'h00FE, t_now);
            begin
                @(posedge clk);
                #1 swap_req = 1'b0;
                @(negedge clk);
                checkOutput("stall_wr_ready", 32'(wr_ready), 1);
                checkOutput("ack_one_pulse", 32'(swap_ack), 0);
                @(posedge clk);
                #1 wr_valid = 1'b0;
            end
        join
        checkOutput("b_period0", t_now - t_prev, BASE_PERIOD);
        t_prev = t_now;
        serveRows("b", 1, 7, 8'h00, 8'hA5, t_prev);

        // Frame C: stalled write visible, back not copied; dwell scaling mid-row.
        waitTick("bc", 1'b1);
        serveRows("c", 0, 3, 8'h3C, 8'h00, t_prev);
        serveRow("c_row4", {8'h00, SEL[4]}, t_now);
        checkOutput("c_period4", t_now - t_prev, BASE_PERIOD);
        t_prev = t_now;
        repeat (5) @(posedge clk);
        #1 shift_done = 1'b1;
        @(posedge clk);
        #1 shift_done = 1'b0;
        refresh_speed = 2'd3;
        serveRow("c_row5", {8'h00, SEL[5]}, t_now);
        checkOutput("c_keep_dwell", t_now - t_prev, BASE_PERIOD);
        t_prev = t_now;
        repeat (5) @(posedge clk);
        #1 refresh_speed = 2'd0;
        serveRow("c_row6", {8'h00, SEL[6]}, t_now);
        checkOutput("c_slow_dwell", t_now - t_prev, SLOW_PERIOD);
        t_prev = t_now;
        serveRow("c_row7", {8'h00, SEL[7]}, t_now);
        checkOutput("c_period7", t_now - t_prev, BASE_PERIOD);
        shift_ready = 1'b0;

        // Frame D: driver busy for 50 cycles in LOAD, then exactly one start.
        waitTick("cd", 1'b0);
        @(posedge clk);
        #1 snap = ss_cnt;
        repeat (50) @(posedge clk);
        #1;
        checkOutput("busy_no_start", ss_cnt, snap);
        checkOutput("busy_row", 32'(row_idx), 0);
        shift_ready = 1'b1;
        serveRow("d_row0", 16'h00FE, t_prev);
        checkOutput("busy_one_start", ss_cnt, snap + 1);
        serveRows("d", 1, 1, 8'h3C, 8'h00, t_prev);
        pulseSwap();
        serveRows("d", 2, 5, 8'h3C, 8'h00, t_prev);

        // Reset in the middle of row 5's dwell.
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        checkOutput("mid_rst_word", 32'(shift_word), 32'h00FF);
        checkOutput("mid_rst_row", 32'(row_idx), 0);
        checkOutput("mid_rst_wr_ready", 32'(wr_ready), 0);
        checkOutput("mid_rst_start", 32'(shift_start), 0);
        checkOutput("mid_rst_tick", 32'(frame_tick), 0);
        checkOutput("mid_rst_ack", 32'(swap_ack), 0);
        snap = ss_cnt;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_hold_no_start", ss_cnt, snap);
        reset = 1'b0;

        // Frame E: buffers cleared and pending swap forgotten.
        t_prev = -1;
        serveRows("e", 0, 7, 8'h00, 8'h00, t_prev);
        waitTick("e_end", 1'b0);
        @(posedge clk);
        #1;
        checkOutput("frame_tick_total", ft_cnt, 4);
        checkOutput("swap_ack_total", sa_cnt, 2);
        checkOutput("swap_ack_with_tick", sa_alone, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/matrix_scan_ctrl.md
MATRIX_SCAN_CTRL -- requirements
Module: matrix_scan_ctrl

Interface
REQ-001 SHALL have parameter DWELL_BASE, default 1024: base row on-time in clk cycles.
REQ-002 SHALL have port clk  input  1  system clock (100 MHz domain).
REQ-003 SHALL have port reset  input  1  reset; one clock, asynchronous and active-high.
REQ-004 SHALL have port refresh_speed  input  2  dwell scale select.
REQ-005 SHALL have port wr_valid  input  1  back-buffer row write request.
REQ-006 SHALL have port wr_ready  output  1  write accepted when wr_valid&&wr_ready.
REQ-007 SHALL have port wr_row  input  3  row index of the write.
REQ-008 SHALL have port wr_data  input  8  column bits of the row; bit0 = column 0, 1 = lit.
REQ-009 SHALL have port swap_req  input  1  request front/back swap at the next frame boundary.
REQ-010 SHALL have port swap_ack  output  1  one-cycle pulse when the swap occurs.
REQ-011 SHALL have port shift_ready  input  1  shift driver idle.
REQ-012 SHALL have port shift_start  output  1  one-cycle pulse: driver latches shift_word.
REQ-013 SHALL have port shift_word  output  16  [15:8] column data, [7:0] row select (active-low, one-hot zero).
REQ-014 SHALL have port shift_done  input  1  one-cycle pulse: word shifted and latched.
REQ-015 SHALL have port row_idx  output  3  row currently displayed.
REQ-016 SHALL have port frame_tick  output  1  one-cycle pulse when row 7 finishes.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, SHIFT, DWELL.
REQ-018 IDLE -> LOAD on the first clk after reset deasserts.
REQ-019 LOAD: when shift_ready=1, assert shift_start for exactly one cycle with shift_word = {front[row_idx], ~(8'h01<<row_idx)} and go to SHIFT; otherwise hold in LOAD with shift_start=0.
REQ-020 shift_word SHALL stay stable from shift_start until the next LOAD.
REQ-021 SHIFT: wait for shift_done, then go to DWELL; the counter is loaded with DWELL_BASE<<refresh_speed, with refresh_speed sampled at that transition.
REQ-022 DWELL: decrement every cycle; on reaching 0, row_idx increments (7 wraps to 0) and the FSM returns to LOAD.
REQ-023 Period per row SHALL be: LOAD wait + shift time + DWELL_BASE<<refresh_speed + 1 cycles.
REQ-024 On the 7->0 wrap, frame_tick SHALL pulse for one cycle in the same cycle row_idx becomes 0.
REQ-025 swap_req=1 on any cycle SHALL set a pending flag; multiple requests before a boundary merge into one swap.
REQ-026 At the 7->0 wrap with pending set: front/back exchange, swap_ack pulses coincident with frame_tick, pending clears.
REQ-027 swap_req asserted in the swap cycle itself SHALL set pending again, for the next frame.
REQ-028 The back buffer SHALL not be copied on swap; the new back buffer holds the old front contents.
REQ-029 Writes SHALL go only to the back buffer and be visible on the display only after a swap.
REQ-030 wr_ready SHALL be 1 except during reset and in the swap cycle, where it is 0; a write that cycle stalls to the next cycle.
REQ-031 A shift_done outside SHIFT SHALL be ignored.

Reset
REQ-032 Reset SHALL asynchronously force: state IDLE, row_idx 0, shift_word 16'h00FF, shift_start 0, swap_ack 0, frame_tick 0, wr_ready 0, pending 0, dwell counter 0, both buffers all-zero, front = buffer 0.
REQ-033 Reset mid-SHIFT or mid-DWELL SHALL abandon the row with no further shift_start; after release, scanning restarts at row 0.

Structure
REQ-034 A shared package matrix_pkg SHALL hold ROWS=8, COLS=8, WORD_W=16, the state enum and a row-select function.
REQ-035 The double buffer SHALL be one sub-module, matrix_fb: two 8x8 arrays, a front-select bit, a write port, a read port and a swap input.
REQ-036 Target size is 120-400 RTL lines total.

Verification
REQ-037 Release reset, shift_ready=1, done 4 cycles after start, DWELL_BASE=16, speed 0 -> shift_word 16'h00FE, then 16'h00FD, ...; row period constant; frame_tick once per 8 rows.
REQ-038 Write row 3 = 8'hA5, no swap -> displayed row 3 stays 8'h00; swap_req pulse -> swap_ack with frame_tick; next frame row 3 word = 16'hA5F7.
REQ-039 Change refresh_speed 0->3 mid-DWELL -> current row keeps old dwell; next row dwell = 128 cycles.
REQ-040 Write and frame-boundary swap in the same cycle -> wr_ready=0 that cycle; write lands next cycle in the new back buffer.
REQ-041 shift_ready held 0 for 50 cycles in LOAD -> no shift_start; exactly one start after ready rises.
REQ-042 Assert reset mid-DWELL on row 5 -> outputs take reset values immediately; after release, first word 16'h00FE and buffers cleared.
